// File: rtl/ssd_disp_ctrl.sv
// rtl/ssd_disp_ctrl.sv - eight-digit seven-segment status/alert display controller
module ssd_disp_ctrl #(
    parameter int TICK_DIV     = 25000000,
    parameter int ALERT_BLINKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] floor,
    input  logic [1:0] dir,
    input  logic       door_open,
    input  logic       alert_req,
    input  logic [3:0] alert_code,
    input  logic       alert_clr,
    output logic       alert_ack,
    output logic       busy,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic [7:0] f,
    output logic [7:0] g,
    output logic [7:0] p
);

    typedef enum logic [1:0] {
        ST_STATUS    = 2'd0,
        ST_ALERT_ON  = 2'd1,
        ST_ALERT_OFF = 2'd2
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
    localparam logic [3:0]  BLINK_END = 4'(ALERT_BLINKS);

    // glyph bit order is {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_R     = 7'h2F;
    localparam logic [6:0] G_U     = 7'h41;
    localparam logic [6:0] G_D     = 7'h21;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_O     = 7'h40;
    localparam logic [6:0] G_P     = 7'h0C;
    localparam logic [6:0] G_C     = 7'h46;
    localparam logic [6:0] G_L     = 7'h47;
    localparam logic [6:0] G_BLANK = 7'h7F;

    state_t      state;
    state_t      state_nx;
    logic [23:0] tick_cnt;
    logic [3:0]  blink_cnt;
    logic [3:0]  code_q;
    logic        tick;
    logic        accept;
    logic        clr_active;
    logic [3:0]  blink_inc;
    logic [6:0]  digit_gl [8];
    logic [7:0]  a_nx, b_nx, c_nx, d_nx, e_nx, f_nx, g_nx;

    assign tick       = (tick_cnt == TICK_LAST);
    assign accept     = (state == ST_STATUS) && alert_req;
    assign clr_active = alert_clr && (state != ST_STATUS);
    assign blink_inc  = blink_cnt + 4'd1;

    // decimal digit glyph; anything above 9 shows a dash
    function automatic logic [6:0] num_glyph(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return G_DASH;
        endcase
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_STATUS;
        else       state <= state_nx;
    end

    // next-state: abort beats the phase tick, blink pairs end the alert
    always_comb begin
        state_nx = state;
        case (state)
            ST_STATUS: begin
                if (alert_req) state_nx = ST_ALERT_ON;
            end
            ST_ALERT_ON: begin
                if (alert_clr)  state_nx = ST_STATUS;
                else if (tick)  state_nx = ST_ALERT_OFF;
            end
            ST_ALERT_OFF: begin
                if (alert_clr)  state_nx = ST_STATUS;
                else if (tick)  state_nx = (blink_inc == BLINK_END) ? ST_STATUS : ST_ALERT_ON;
            end
            default: state_nx = ST_STATUS;
        endcase
    end

    // phase timer, blink pair counter and alert code latch
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            blink_cnt <= '0;
            code_q    <= '0;
        end else begin
            if (accept || tick) tick_cnt <= '0;
            else                tick_cnt <= tick_cnt + 24'd1;

            if (accept || clr_active)
                blink_cnt <= '0;
            else if (state == ST_ALERT_OFF && tick)
                blink_cnt <= (blink_inc == BLINK_END) ? 4'd0 : blink_inc;

            if (accept) code_q <= alert_code;
        end
    end

    // handshake and busy flags, registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            alert_ack <= 1'b0;
            busy      <= 1'b0;
        end else begin
            alert_ack <= accept;
            busy      <= (state_nx != ST_STATUS);
        end
    end

    // per-digit glyph selection for the current state
    always_comb begin
        for (int k = 0; k < 8; k++) digit_gl[k] = G_BLANK;
        case (state)
            ST_STATUS: begin
                digit_gl[0] = num_glyph(floor);
                case (dir)
                    2'b01:   digit_gl[2] = G_U;
                    2'b10:   digit_gl[2] = G_D;
                    default: digit_gl[2] = G_DASH;
                endcase
                digit_gl[5] = door_open ? G_O : G_C;
                digit_gl[4] = door_open ? G_P : G_L;
            end
            ST_ALERT_ON: begin
                digit_gl[7] = G_E;
                digit_gl[6] = G_R;
                digit_gl[5] = G_R;
                digit_gl[0] = num_glyph(code_q);
            end
            default: ;
        endcase
    end

    // transpose digit glyphs into per-segment vectors
    always_comb begin
        a_nx = '1; b_nx = '1; c_nx = '1; d_nx = '1;
        e_nx = '1; f_nx = '1; g_nx = '1;
        for (int k = 0; k < 8; k++) begin
            a_nx[k] = digit_gl[k][0];
            b_nx[k] = digit_gl[k][1];
            c_nx[k] = digit_gl[k][2];
            d_nx[k] = digit_gl[k][3];
            e_nx[k] = digit_gl[k][4];
            f_nx[k] = digit_gl[k][5];
            g_nx[k] = digit_gl[k][6];
        end
    end

    // segment output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= 8'hFF; b <= 8'hFF; c <= 8'hFF; d <= 8'hFF;
            e <= 8'hFF; f <= 8'hFF; g <= 8'hFF;
        end else begin
            a <= a_nx; b <= b_nx; c <= c_nx; d <= d_nx;
            e <= e_nx; f <= f_nx; g <= g_nx;
        end
    end

    // decimal points are never lit
    assign p = 8'hFF;

endmodule

// File: tb/tb_ssd_disp_ctrl.sv
// tb/tb_ssd_disp_ctrl.sv - self-checking bench for ssd_disp_ctrl
module tb_ssd_disp_ctrl;

    localparam int TD    = 4;
    localparam int AB    = 2;
    localparam int TOTAL = 2 * AB * TD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] floor;
    logic [1:0] dir;
    logic       door_open;
    logic       alert_req;
    logic [3:0] alert_code;
    logic       alert_clr;
    logic       alert_ack;
    logic       busy;
    logic [7:0] a, b, c, d, e, f, g, p;

    int checks = 0;
    int errors = 0;

    // reference model: alert is a span of TOTAL cycles measured from acceptance
    bit         m_busy = 1'b0;
    int         m_elapsed = 0;
    logic [3:0] m_code = 4'd0;
    bit         last_exp_ack = 1'b0;

    ssd_disp_ctrl #(.TICK_DIV(TD), .ALERT_BLINKS(AB)) dut (
        .clk(clk), .reset(reset), .floor(floor), .dir(dir), .door_open(door_open),
        .alert_req(alert_req), .alert_code(alert_code), .alert_clr(alert_clr),
        .alert_ack(alert_ack), .busy(busy),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .p(p)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_of(byte ch);
        case (ch)
            "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;
            "3": return 7'h30;  "4": return 7'h19;  "5": return 7'h12;
            "6": return 7'h02;  "7": return 7'h78;  "8": return 7'h00;
            "9": return 7'h10;  "E": return 7'h06;  "r": return 7'h2F;
            "U": return 7'h41;  "d": return 7'h21;  "-": return 7'h3F;
            "O": return 7'h40;  "P": return 7'h0C;  "C": return 7'h46;
            "L": return 7'h47;  default: return 7'h7F;
        endcase
    endfunction

    function automatic byte digit_char(logic [3:0] v);
        if (v <= 4'd9) return byte'(8'h30 + {4'd0, v});
        return "-";
    endfunction

    // 0 = status, 1 = alert shown, 2 = alert dark
    function automatic int model_mode();
        if (!m_busy) return 0;
        return ((m_elapsed / TD) % 2 == 0) ? 1 : 2;
    endfunction

    // expected {p,g,f,e,d,c,b,a}; byte j holds segment j, bit k within it is digit k
    function automatic logic [63:0] expect_segs(int mode, logic [3:0] fl, logic [1:0] dr,
                                                logic dopen, logic [3:0] code);
        byte         ch [8];
        logic [6:0]  gl;
        logic [63:0] v;
        for (int k = 0; k < 8; k++) ch[k] = " ";
        if (mode == 0) begin
            ch[0] = digit_char(fl);
            if (dr == 2'b01)      ch[2] = "U";
            else if (dr == 2'b10) ch[2] = "d";
            else                  ch[2] = "-";
            ch[5] = dopen ? "O" : "C";
            ch[4] = dopen ? "P" : "L";
        end else if (mode == 1) begin
            ch[7] = "E"; ch[6] = "r"; ch[5] = "r";
            ch[0] = digit_char(code);
        end
        v = '1;
        for (int k = 0; k < 8; k++) begin
            gl = glyph_of(ch[k]);
            for (int j = 0; j < 7; j++) v[8*j + k] = gl[j];
        end
        return v;
    endfunction

    function automatic logic [6:0] glyph_at(int k);
        return {g[k], f[k], e[k], d[k], c[k], b[k], a[k]};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(string tag, int k, logic [6:0] exp);
        chk(tag, {57'd0, glyph_at(k)}, {57'd0, exp});
    endtask

    // one clock: predict from pre-edge inputs, advance model, compare after the edge
    task automatic step(string tag);
        logic [63:0] exp_seg;
        logic        exp_ack;
        exp_seg = reset ? 64'hFFFF_FFFF_FFFF_FFFF
                        : expect_segs(model_mode(), floor, dir, door_open, m_code);
        exp_ack = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_elapsed = 0; m_code = 4'd0;
        end else if (!m_busy) begin
            if (alert_req) begin
                m_busy = 1'b1; m_elapsed = 0; m_code = alert_code; exp_ack = 1'b1;
            end
        end else if (alert_clr) begin
            m_busy = 1'b0;
        end else begin
            m_elapsed++;
            if (m_elapsed == TOTAL) m_busy = 1'b0;
        end
        last_exp_ack = exp_ack;
        @(posedge clk);
        #1;
        chk({tag, "_seg"}, {p, g, f, e, d, c, b, a}, exp_seg);
        chk({tag, "_ack"}, {63'd0, alert_ack}, {63'd0, exp_ack});
        chk({tag, "_busy"}, {63'd0, busy}, {63'd0, m_busy});
    endtask

    initial begin
        int n_ack;
        int n;
        reset = 1'b1; floor = 4'd0; dir = 2'b00; door_open = 1'b0;
        alert_req = 1'b0; alert_code = 4'd0; alert_clr = 1'b0;
        step("rst0");
        step("rst1");

        // first status pattern one cycle after reset release
        reset = 1'b0; floor = 4'd3; dir = 2'b01; door_open = 1'b1;
        step("status");
        chk_g("st_g0", 0, 7'h30);
        chk_g("st_g2", 2, 7'h41);
        chk_g("st_g5", 5, 7'h40);
        chk_g("st_g4", 4, 7'h0C);
        chk_g("st_g1", 1, 7'h7F);
        chk_g("st_g7", 7, 7'h7F);

        // full alert with request held for three cycles
        alert_req = 1'b1; alert_code = 4'd7; n_ack = 0;
        repeat (3) begin step("alert1"); n_ack += int'(alert_ack); end
        chk_g("on_g7", 7, 7'h06);
        chk_g("on_g6", 6, 7'h2F);
        chk_g("on_g5", 5, 7'h2F);
        chk_g("on_g0", 0, 7'h78);
        alert_req = 1'b0;
        repeat (16) begin step("alert1"); n_ack += int'(alert_ack); end
        chk("alert1_ack_count", 64'(n_ack), 64'd1);

        // abort two cycles into the dark phase
        alert_req = 1'b1; alert_code = 4'd5;
        step("clr_acc");
        alert_req = 1'b0; n_ack = 0;
        repeat (6) step("clr_run");
        alert_clr = 1'b1;
        step("clr_hit");
        alert_clr = 1'b0;
        repeat (3) begin step("clr_after"); n_ack += int'(alert_ack); end
        chk("clr_no_ack", 64'(n_ack), 64'd0);

        // request raised mid-alert is held off until status returns
        alert_req = 1'b1; alert_code = 4'd2;
        step("req2_acc");
        alert_code = 4'd9; n = 0;
        for (int i = 0; i < 40; i++) begin
            step("req2_wait"); n++;
            if (alert_ack) break;
        end
        chk("req2_ack_delay", 64'(n), 64'(TOTAL + 1));
        alert_req = 1'b0;
        step("req2_show");
        chk_g("req2_code", 0, 7'h10);
        alert_clr = 1'b1;
        step("req2_clr");
        alert_clr = 1'b0;
        step("req2_idle");

        // reset in the middle of an alert, then an off-range floor
        alert_req = 1'b1; alert_code = 4'd4;
        step("rmid_acc");
        alert_req = 1'b0;
        repeat (2) step("rmid_run");
        reset = 1'b1; alert_req = 1'b1; alert_clr = 1'b1;
        step("rmid_rst");
        chk("rmid_allff", {p, g, f, e, d, c, b, a}, 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b0; alert_req = 1'b0; alert_clr = 1'b0; floor = 4'd12;
        step("rmid_floor");
        chk_g("floor12_g0", 0, 7'h3F);

        // abort on the final tick, then a complete alert
        alert_req = 1'b1; alert_code = 4'd8;
        step("last_acc");
        alert_req = 1'b0;
        repeat (TOTAL - 1) step("last_run");
        alert_clr = 1'b1;
        step("last_clr");
        alert_clr = 1'b0;
        alert_req = 1'b1; alert_code = 4'd1;
        step("full_acc");
        alert_req = 1'b0; n = 0;
        for (int i = 0; i < 40; i++) begin
            step("full_run"); n++;
            if (!busy) break;
        end
        chk("full_len", 64'(n), 64'(TOTAL));

        // randomized traffic against the model
        repeat (500) begin
            floor     = 4'($urandom_range(0, 15));
            dir       = 2'($urandom_range(0, 3));
            door_open = 1'($urandom_range(0, 1));
            if (!alert_req && $urandom_range(0, 9) == 0) begin
                alert_req  = 1'b1;
                alert_code = 4'($urandom_range(0, 15));
            end
            alert_clr = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step("rand");
            if (last_exp_ack) alert_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_disp_ctrl.md
SSD_DISP_CTRL -- requirements
Module: ssd_disp_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per blink phase (legal range 2..2^24).
REQ-002 Parameter ALERT_BLINKS, default 4, number of on/off blink pairs per alert (legal range 1..15).
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 floor  in  4  current floor, 0..9 displayable.
REQ-006 dir  in  2  car direction: 00 idle, 01 up, 10 down, 11 invalid.
REQ-007 door_open  in  1  door status, 1 = open.
REQ-008 alert_req  in  1  alert request; level, held by the requester until acked.
REQ-009 alert_code  in  4  alert code, valid while alert_req=1.
REQ-010 alert_clr  in  1  one-cycle abort of an active alert.
REQ-011 alert_ack  out  1  one-cycle acceptance pulse.
REQ-012 busy  out  1  1 while an alert is being shown.
REQ-013 a,b,c,d,e,f,g,p  out  8 each  active-low segment vectors; bit k drives digit k (digit0 rightmost); feeds the ssd multiplexer directly.

Function
REQ-014 Notation: glyph(k) = {g[k],f[k],e[k],d[k],c[k],b[k],a[k]}, with 0 = segment lit.
REQ-015 Glyph codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 E=06 r=2F U=41 d=21 -=3F O=40 P=0C C=46 L=47 blank=7F (hex).
REQ-016 p shall be 8'hFF in every state.
REQ-017 FSM states: STATUS, ALERT_ON, ALERT_OFF.
REQ-018 STATUS layout: digit0 = floor (floor>9 shows '-'), digit2 = 'U' for dir 01, 'd' for dir 10, '-' for dir 00 or 11, digit5/digit4 = "O","P" if door_open else "C","L", all other digits blank.
REQ-019 ALERT_ON layout: digit7/6/5 = "E","r","r", digit0 = latched code (code>9 shows '-'), all other digits blank.
REQ-020 ALERT_OFF layout: all eight digits blank.
REQ-021 Segment outputs are registered and reflect the state and inputs sampled at the previous edge (1-cycle latency).
REQ-022 In STATUS with alert_req=1: on the next edge the state becomes ALERT_ON, alert_code is latched, alert_ack=1 for exactly one cycle, the tick counter clears to 0, and the blink count clears to 0.
REQ-023 alert_req is ignored, with no ack, in ALERT_ON and ALERT_OFF; a request still held on return to STATUS is accepted on the following edge.
REQ-024 Tick counter counts 0..TICK_DIV-1 and wraps; a tick occurs on the cycle the count equals TICK_DIV-1.
REQ-025 On a tick in ALERT_ON the state goes to ALERT_OFF.
REQ-026 On a tick in ALERT_OFF the blink count increments; if the new count equals ALERT_BLINKS the state goes to STATUS, else to ALERT_ON.
REQ-027 Each phase therefore lasts exactly TICK_DIV cycles, and a full alert lasts 2*ALERT_BLINKS*TICK_DIV cycles.
REQ-028 alert_clr=1 in ALERT_ON or ALERT_OFF forces STATUS on the next edge; it has no effect in STATUS.
REQ-029 If alert_clr and a tick coincide, alert_clr wins.
REQ-030 busy=1 exactly while the state is ALERT_ON or ALERT_OFF (registered together with the state).
REQ-031 Status inputs (floor, dir, door_open) changing during an alert do not disturb the alert; STATUS shows their current values on return.

Reset
REQ-032 Reset=1 at any edge shall force: state STATUS, tick counter 0, blink count 0, latched code 0, alert_ack=0, busy=0, and all segment outputs 8'hFF.
REQ-033 Reset has priority over alert_req and alert_clr, including mid-alert.
REQ-034 The first STATUS pattern appears one cycle after reset deasserts.

Verification (TICK_DIV=4, ALERT_BLINKS=2)
REQ-035 Reset, then floor=3, dir=01, door_open=1 -> after 1 cycle: glyph0=30, glyph2=41, glyph5=40, glyph4=0C, others 7F; p=FF; busy=0.
REQ-036 alert_req=1, code=7, held 3 cycles -> exactly one alert_ack pulse. Display then shows ALERT_ON for 4 cycles (glyph7=06, glyph6=2F, glyph5=2F, glyph0=78), ALERT_OFF (all 7F) for 4 cycles, repeated once. STATUS returns 16 cycles after acceptance and busy falls at the same time.
REQ-037 alert_clr pulsed 2 cycles into ALERT_OFF -> STATUS on the next edge; STATUS pattern 1 cycle later; no further ack.
REQ-038 Second alert_req raised mid-alert and held -> no ack until STATUS; ack on the cycle after the return; new code shown.
REQ-039 Reset asserted during ALERT_ON -> next cycle all outputs FF, busy=0; floor=12 after reset -> glyph0=3F.
REQ-040 alert_clr coincident with the final ALERT_OFF tick -> STATUS, blink count 0; a subsequent alert runs its full 16 cycles.
